// File: rtl/child_sched_pkg.sv
// Shared types and helpers for the child-slot round-robin scheduler.
package child_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  // Modular increment; n need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/child_rr_pick.sv
// Rotate-priority encoder: first set req bit at or above ptr, wrapping to 0.
module child_rr_pick #(
  parameter  int unsigned NUM_REQ = 10,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     winner_idx
);

  logic           hit_hi;
  logic [IDW-1:0] idx_hi;
  logic           hit_lo;
  logic [IDW-1:0] idx_lo;

  // Two upward scans: bits at/above ptr take precedence over the wrapped low range.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    hit_lo = 1'b0;
    idx_lo = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (i >= 32'(ptr)) && !hit_hi) begin
        hit_hi = 1'b1;
        idx_hi = IDW'(i);
      end
      if (req[i] && (i < 32'(ptr)) && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = IDW'(i);
      end
    end
  end

  assign any        = hit_hi | hit_lo;
  assign winner_idx = hit_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/child_slot_rr_scheduler.sv
// Round-robin owner of one shared slot among NUM_REQ children, with hold limit
// and a one-cycle turnaround gap between grants.
module child_slot_rr_scheduler
  import child_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 10,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid,
  output logic               hold_expired,
  output logic               busy
);

  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hold_exp_w;

  logic               pick_any;
  logic [IDW-1:0]     pick_idx;
  logic               owner_done;
  logic               owner_req;
  logic [IDW-1:0]     gnt_id_w;

  child_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .any       (pick_any),
    .winner_idx(pick_idx)
  );

  // Masking with the one-hot grant selects only the owner's done/req bits.
  assign owner_done = |(done & gnt_q);
  assign owner_req  = |(req & gnt_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    hold_exp_w = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          ptr_d   = IDW'(rr_next(32'(pick_idx), NUM_REQ));
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (owner_done || !owner_req) begin
          state_d = RELEASE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d    = RELEASE;
          gnt_d      = '0;
          cnt_d      = '0;
          hold_exp_w = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    gnt_id_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gnt_id_w = IDW'(i);
    end
  end

  assign gnt          = gnt_q;
  assign gnt_id       = gnt_id_w;
  assign gnt_valid    = |gnt_q;
  assign hold_expired = hold_exp_w;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_child_slot_rr_scheduler.sv
// Directed bench for child_slot_rr_scheduler: reset, rotation, wrap, hold limit,
// simultaneous release, mid-grant reset.
module tb_child_slot_rr_scheduler;

  localparam int unsigned NR  = 10;
  localparam int unsigned MH  = 16;
  localparam int unsigned IDW = $clog2(NR);

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] done;
  logic [NR-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic          gnt_valid;
  logic          hold_expired;
  logic          busy;

  int unsigned n_checks;
  int unsigned n_fail;

  child_slot_rr_scheduler #(
    .NUM_REQ (NR),
    .MAX_HOLD(MH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .hold_expired(hold_expired),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned id;
    n_checks = 0;
    n_fail   = 0;

    // 1: reset with all requests pending
    rst_n = 1'b0;
    req   = '1;
    done  = '0;
    step();
    step();
    check("rst_gnt",    32'(gnt), 32'h0);
    check("rst_gnt_id", 32'(gnt_id), 32'h0);
    check("rst_valid",  32'(gnt_valid), 32'h0);
    check("rst_hexp",   32'(hold_expired), 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    rst_n = 1'b1;
    step();
    check("first_gnt",   32'(gnt), 32'h1);
    check("first_id",    32'(gnt_id), 32'h0);
    check("first_valid", 32'(gnt_valid), 32'h1);
    check("first_busy",  32'(busy), 32'h1);

    // 2: rotation 0..9,0 with done after 3 grant cycles and one-cycle gap
    for (int unsigned i = 0; i <= 10; i++) begin
      id = i % NR;
      check("rot_id",  32'(gnt_id), id);
      check("rot_gnt", 32'(gnt), 32'(1) << id);
      step();
      step();
      done = NR'(1) << id;
      step();
      done = '0;
      check("rot_gap",  32'(gnt), 32'h0);
      check("rot_busy", 32'(busy), 32'h1);
      check("rot_hexp", 32'(hold_expired), 32'h0);
      if (i < 10) step();
    end

    // 3: wrap from child 9 back to 0, then 2, then 9
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
    req   = NR'(1) << 9;
    step();
    check("wrap_9", 32'(gnt_id), 32'd9);
    req  = (NR'(1) << 9) | (NR'(1) << 2) | NR'(1);
    done = NR'(1) << 9;
    step();
    done = '0;
    check("wrap_gap", 32'(gnt), 32'h0);
    step();
    check("wrap_0", 32'(gnt_id), 32'd0);
    req  = (NR'(1) << 9) | (NR'(1) << 2);
    done = NR'(1);
    step();
    done = '0;
    step();
    check("wrap_2", 32'(gnt_id), 32'd2);
    req = NR'(1) << 9;
    step();
    step();
    check("wrap_9b", 32'(gnt_id), 32'd9);
    req = '0;
    step();
    step();
    check("wrap_idle_busy", 32'(busy), 32'h0);
    check("wrap_idle_gnt",  32'(gnt), 32'h0);

    // 4: hold limit on child 4
    req = NR'(1) << 4;
    step();
    for (int unsigned c = 1; c <= MH; c++) begin
      check("hold_gnt",  32'(gnt), 32'h10);
      check("hold_hexp", 32'(hold_expired), (c == MH) ? 32'h1 : 32'h0);
      if (c < MH) step();
    end
    step();
    check("hold_gap",  32'(gnt), 32'h0);
    check("hold_hexp_rel", 32'(hold_expired), 32'h0);
    step();
    check("hold_regrant", 32'(gnt_id), 32'd4);

    // 5: done coincident with limit releases without pulse; foreign done ignored
    for (int unsigned c = 1; c <= MH; c++) begin
      done = (c == 3) ? (NR'(1) << 7) : (c == MH) ? (NR'(1) << 4) : '0;
      #1;
      check("sim_gnt",  32'(gnt), 32'h10);
      check("sim_hexp", 32'(hold_expired), 32'h0);
      if (c < MH) step();
    end
    step();
    done = '0;
    check("sim_gap",  32'(gnt), 32'h0);
    check("sim_hexp_rel", 32'(hold_expired), 32'h0);
    step();
    check("sim_regrant", 32'(gnt_id), 32'd4);

    // 6: reset mid-grant of child 6, pointer returns to 0
    req = NR'(1) << 6;
    step();
    step();
    check("mid_6", 32'(gnt_id), 32'd6);
    req = (NR'(1) << 6) | (NR'(1) << 2);
    step();
    check("mid_hold6", 32'(gnt), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_gnt",   32'(gnt), 32'h0);
    check("mid_async_valid", 32'(gnt_valid), 32'h0);
    check("mid_async_busy",  32'(busy), 32'h0);
    check("mid_async_hexp",  32'(hold_expired), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_after_2", 32'(gnt_id), 32'd2);
    check("mid_after_gnt", 32'(gnt), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
